// File: rtl/led_breath_pwm_pkg.sv
// Shared types and helpers for the breathing-LED PWM stage.
// gamma_map is used only when LED_BREATH_GAMMA_EN is defined.
package led_breath_pkg;

   typedef enum logic [1:0] {
      ST_OFF       = 2'd0,
      ST_FADE_UP   = 2'd1,
      ST_ON        = 2'd2,
      ST_FADE_DOWN = 2'd3
   } state_e;

   function automatic int lmax_of(input int bits);
      return (1 << bits) - 1;
   endfunction

   // Squared-law brightness: duty = level*(level+1) >> bits, exact at 0 and LMAX.
   function automatic logic [31:0] gamma_map(input logic [31:0] lvl, input int bits);
      logic [63:0] prod;
      logic [63:0] shifted;
      prod    = {32'd0, lvl} * {32'd0, lvl + 32'd1};
      shifted = prod >> bits;
      return shifted[31:0];
   endfunction

endpackage

// File: rtl/led_breath_pwm_if.sv
// Control/status bundle between the blinker side and the breathing-LED stage.
interface led_breath_pwm_if #(
   parameter int PWM_BITS = 8
);
   logic                enable;
   logic                led_in;
   logic                led_pwm;
   logic [PWM_BITS-1:0] level;
   logic                busy;
   logic                done;

   modport master (
      output enable, led_in,
      input  led_pwm, level, busy, done
   );

   modport slave (
      input  enable, led_in,
      output led_pwm, level, busy, done
   );
endinterface

// File: rtl/led_breath_pwm_gen.sv
// Free-running PWM counter, duty comparator and registered LED drive.
module led_pwm_gen
   import led_breath_pkg::*;
#(
   parameter int PWM_BITS = 8
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [PWM_BITS-1:0] i_duty,
   input  logic                i_enable,
   output logic                o_led_pwm
);
   localparam int LMAX = lmax_of(PWM_BITS);
   localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'(LMAX - 1);

   logic [PWM_BITS-1:0] r_cnt;
   logic                r_pwm;

   // Period is LMAX, so duty LMAX stays high and duty 0 stays low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_pwm <= 1'b0;
      end else if (!i_enable) begin
         r_cnt <= '0;
         r_pwm <= 1'b0;
      end else begin
         r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + PWM_BITS'(1);
         r_pwm <= (r_cnt < i_duty);
      end
   end

   assign o_led_pwm = r_pwm;

endmodule

// File: rtl/led_breath_pwm.sv
// Breathing-LED stage: ramps brightness up/down on each change of led_in.
// Define LED_BREATH_GAMMA_EN for a squared-law duty curve; default is linear.
module led_breath_pwm
   import led_breath_pkg::*;
#(
   parameter int PWM_BITS = 8,
   parameter int STEP_DIV = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   led_breath_pwm_if.slave  bus
);
   localparam int LMAX = lmax_of(PWM_BITS);
   localparam logic [PWM_BITS-1:0] LVL_MAX = PWM_BITS'(LMAX);
   localparam logic [PWM_BITS-1:0] LVL_ONE = PWM_BITS'(1);
   localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);

   localparam logic [1:0] S_OFF       = ST_OFF;
   localparam logic [1:0] S_FADE_UP   = ST_FADE_UP;
   localparam logic [1:0] S_ON        = ST_ON;
   localparam logic [1:0] S_FADE_DOWN = ST_FADE_DOWN;

   logic [1:0]          r_state;
   logic [PWM_BITS-1:0] r_level;
   logic [SW-1:0]       r_step;
   logic                r_busy;
   logic                r_done;

   logic [1:0]          w_state_next;
   logic [PWM_BITS-1:0] w_level_next;
   logic [SW-1:0]       w_step_next;
   logic                w_done_next;
   logic                w_busy_next;
   logic                w_tick;
   logic [PWM_BITS-1:0] w_duty;

   assign w_tick = (r_step == STEP_LAST);

   always_comb begin
      w_state_next = r_state;
      w_level_next = r_level;
      w_step_next  = r_step;
      w_done_next  = 1'b0;

      case (r_state)
         S_OFF: begin
            if (bus.led_in) w_state_next = S_FADE_UP;
         end
         S_FADE_UP: begin
            // A reversal wins over a coincident tick and leaves the level untouched.
            if (!bus.led_in) begin
               w_state_next = S_FADE_DOWN;
            end else if (w_tick) begin
               w_step_next = '0;
               if (r_level >= LVL_MAX - LVL_ONE) begin
                  w_level_next = LVL_MAX;
                  w_state_next = S_ON;
                  w_done_next  = 1'b1;
               end else begin
                  w_level_next = r_level + LVL_ONE;
               end
            end else begin
               w_step_next = r_step + SW'(1);
            end
         end
         S_ON: begin
            if (!bus.led_in) w_state_next = S_FADE_DOWN;
         end
         S_FADE_DOWN: begin
            if (bus.led_in) begin
               w_state_next = S_FADE_UP;
            end else if (w_tick) begin
               w_step_next = '0;
               if (r_level <= LVL_ONE) begin
                  w_level_next = '0;
                  w_state_next = S_OFF;
                  w_done_next  = 1'b1;
               end else begin
                  w_level_next = r_level - LVL_ONE;
               end
            end else begin
               w_step_next = r_step + SW'(1);
            end
         end
         default: begin
            w_state_next = S_OFF;
         end
      endcase

      if (w_state_next != r_state) w_step_next = '0;

      if (!bus.enable) begin
         w_state_next = S_OFF;
         w_level_next = '0;
         w_step_next  = '0;
         w_done_next  = 1'b0;
      end
   end

   assign w_busy_next = (w_state_next == S_FADE_UP) || (w_state_next == S_FADE_DOWN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_OFF;
         r_level <= '0;
         r_step  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_level <= w_level_next;
         r_step  <= w_step_next;
         r_busy  <= w_busy_next;
         r_done  <= w_done_next;
      end
   end

`ifdef LED_BREATH_GAMMA_EN
   assign w_duty = PWM_BITS'(gamma_map(32'(r_level), PWM_BITS));
`else
   assign w_duty = r_level;
`endif

   led_pwm_gen #(
      .PWM_BITS (PWM_BITS)
   ) u_pwm_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_duty    (w_duty),
      .i_enable  (bus.enable),
      .o_led_pwm (bus.led_pwm)
   );

   assign bus.level = r_level;
   assign bus.busy  = r_busy;
   assign bus.done  = r_done;

endmodule

// File: tb/tb_led_breath_pwm.sv
// Scoreboard bench for led_breath_pwm (PWM_BITS=4, STEP_DIV=2).
module tb_led_breath_pwm;
   localparam int PW = 4;
   localparam int SD = 2;
   localparam int LM = 15;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   led_breath_pwm_if #(.PWM_BITS(PW)) bus_if();

   led_breath_pwm #(
      .PWM_BITS (PW),
      .STEP_DIV (SD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   typedef struct {
      int level;
      bit busy;
      bit done;
      bit pwm;
   } exp_t;

   exp_t sb[$];
   int n_vec = 0;
   int n_err = 0;

   // Reference model: brightness, fade direction (+1/-1, 0 = settled),
   // cycles since last step, and position within the PWM period.
   int m_lvl, m_dir, m_age, m_phase;

   task automatic check(string name, int got, int want);
      n_vec++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, want %0d", name, $time, got, want);
      end
   endtask

   function automatic int duty_of(int l);
`ifdef LED_BREATH_GAMMA_EN
      return (l * (l + 1)) / (LM + 1);
`else
      return l;
`endif
   endfunction

   task automatic model_reset();
      m_lvl = 0; m_dir = 0; m_age = 0; m_phase = 0;
   endtask

   task automatic model_step(bit en, bit li, output exp_t e);
      e.done = 1'b0;
      if (!en) begin
         model_reset();
         e.pwm = 1'b0;
      end else begin
         e.pwm   = (m_phase < duty_of(m_lvl));
         m_phase = (m_phase + 1) % LM;
         if (m_dir == 0) begin
            if (li && m_lvl != LM)      begin m_dir = 1;  m_age = 0; end
            else if (!li && m_lvl != 0) begin m_dir = -1; m_age = 0; end
         end else if ((m_dir > 0) != li) begin
            m_dir = li ? 1 : -1;
            m_age = 0;
         end else begin
            m_age++;
            if (m_age == SD) begin
               m_age = 0;
               m_lvl = m_lvl + m_dir;
               if (m_lvl > LM) m_lvl = LM;
               if (m_lvl < 0)  m_lvl = 0;
               if (m_lvl == (li ? LM : 0)) begin
                  m_dir  = 0;
                  e.done = 1'b1;
               end
            end
         end
      end
      e.level = m_lvl;
      e.busy  = (m_dir != 0);
   endtask

   task automatic drive(bit en, bit li);
      exp_t e;
      @(negedge clk);
      bus_if.enable = en;
      bus_if.led_in = li;
      model_step(en, li, e);
      sb.push_back(e);
   endtask

   task automatic segment(string tag, bit en, bit li, int n);
      for (int i = 0; i < n; i++) drive(en, li);
      $display("txn %-8s en=%0d led_in=%0d cycles=%0d model_level=%0d model_busy=%0d",
               tag, en, li, n, m_lvl, (m_dir != 0));
   endtask

   // Monitor: one expected tuple per clock edge, compared just after the edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin : cmp
            exp_t e;
            e = sb.pop_front();
            check("level",   int'(bus_if.level),   e.level);
            check("busy",    int'(bus_if.busy),    int'(e.busy));
            check("done",    int'(bus_if.done),    int'(e.done));
            check("led_pwm", int'(bus_if.led_pwm), int'(e.pwm));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog at %0t: got timeout, want completion", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int highs;
      bus_if.enable = 1'b0;
      bus_if.led_in = 1'b0;
      model_reset();

      #12;
      check("rst_level", int'(bus_if.level),   0);
      check("rst_busy",  int'(bus_if.busy),    0);
      check("rst_done",  int'(bus_if.done),    0);
      check("rst_pwm",   int'(bus_if.led_pwm), 0);
      @(negedge clk);
      rst_n = 1'b1;

      segment("idle",    1, 0, 3);
      segment("fade_up", 1, 1, 35);
      segment("fade_dn", 1, 0, 35);

      segment("up_to4",  1, 1, 9);
      segment("rev_dn",  1, 0, 12);

      segment("clear",   0, 0, 2);
      segment("up_to5",  1, 1, 11);
      highs = 0;
      for (int i = 0; i < 45; i++) begin
         drive(1, (i % 2) == 1);
         @(posedge clk);
         #1;
         highs += int'(bus_if.led_pwm);
      end
      $display("txn hold5    en=1 led_in=toggle cycles=45 model_level=%0d highs=%0d", m_lvl, highs);
      check("hold5_highs", highs, 3 * duty_of(5));

      segment("clear",   0, 0, 2);
      segment("up_to9",  1, 1, 19);
      segment("disable", 0, 1, 3);
      segment("reen",    1, 1, 6);

      segment("clear",   0, 0, 2);
      segment("mid",     1, 1, 10);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_level", int'(bus_if.level),   0);
      check("arst_busy",  int'(bus_if.busy),    0);
      check("arst_done",  int'(bus_if.done),    0);
      check("arst_pwm",   int'(bus_if.led_pwm), 0);
      bus_if.enable = 1'b0;
      model_reset();
      drive(0, 0);
      rst_n = 1'b1;
      $display("txn arst     en=0 led_in=0 cycles=1 model_level=%0d model_busy=0", m_lvl);

      for (int s = 0; s < 60; s++) begin
         bit en;
         bit li;
         int n;
         en = ($urandom_range(0, 7) != 0);
         li = 1'($urandom_range(0, 1));
         n  = (s % 4 == 0) ? $urandom_range(1, 3) : $urandom_range(1, 40);
         segment("rand", en, li, n);
      end

      repeat (2) @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
